mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port 16-bit data memory between the CPU control unit and a DMA/loader requester. It accepts level-held requests, grants one owner at a time using round-robin, and drives the memory for a fixed read latency. It returns one-cycle acknowledge pulses with registered read data. It sits between the control unit/AR-DR datapath and the memory array, so the CPU FSM can wait on `cpu_ack` instead of counting fixed idle states.

## Interface
- `ADDR_W`, default 10: address width, matching the IR[9:0] direct-address field.
- `DATA_W`, default 16: data bus width.
- `RD_LAT`, default 3: memory read latency in cycles, 1 or more.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_req` in 1: CPU access request, level-held until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: CPU address (from AR).
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_ack` out 1: one-cycle completion pulse to the CPU.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`: same as the CPU-side inputs, for the DMA requester.
- `dma_ack` out 1: one-cycle completion pulse to the DMA.
- `rdata` out DATA_W: registered read data, valid in the ack cycle.
- `mem_en` out 1: memory enable.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid RD_LAT cycles after `mem_en` first rises.
- `busy` out 1: high in any state other than IDLE.
- `owner` out 1: current or last grant; 0 = CPU, 1 = DMA.

## Operation
- State machine has three states: IDLE, ACCESS, DONE.
- **IDLE**
  - No request: stay in IDLE.
  - Otherwise pick the owner and go to ACCESS. On the same edge, latch the owner's `we`, `addr` and `wdata` into the `mem_*` registers.
  - Load counter `cnt` with RD_LAT-1 for a read, or 0 for a write.
- **Arbitration**
  - Only one request: it wins.
  - Both requesting: the requester that did not win last time wins.
  - `owner` resets to 1, so the CPU wins the first tie.
- **ACCESS**
  - `mem_en`=1 throughout; `mem_addr`, `mem_wdata` and `mem_we` are held stable.
  - Requests arriving during ACCESS are ignored and do not change the latched fields.
  - `cnt`≠0: decrement `cnt`.
  - `cnt`=0: go to DONE. For a read, capture `mem_rdata` into `rdata` on this edge. For a write, `rdata` is unchanged.
  - On the same edge, drive `mem_en` and `mem_we` to 0.
- **DONE**
  - Pulse `cpu_ack` or `dma_ack`, selected by `owner`, for exactly one cycle.
  - Go to IDLE unconditionally.
- **Requester rule**
  - The requester drops `req` on the edge that ends its ack cycle.
  - A requester needing another access re-asserts `req` no earlier than the IDLE cycle.
  - A `req` still high in IDLE is treated as a new transaction.
- The arbiter never asserts both acks in the same cycle.
- `mem_we` is high only during a write ACCESS cycle, never outside ACCESS.

## Timing
- **Reset values**
  - State IDLE, `cnt`=0, `owner`=1.
  - `cpu_ack`=0, `dma_ack`=0, `rdata`=0, `busy`=0.
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- **Read latency:** request seen in IDLE at edge T; ACCESS covers cycles T+1 … T+RD_LAT; ack is high in cycle T+RD_LAT+1.
  - With RD_LAT=3, the ack arrives 4 cycles after the request.
- **Write latency:** ACCESS lasts one cycle; ack is high in cycle T+2.
- **Throughput:** back-to-back transactions take a minimum of RD_LAT+2 cycles per read and 3 cycles per write, because IDLE is always one cycle.
- **Contention:** the loser keeps `req` high and is granted at the IDLE following the winner's DONE. Worst-case wait is one full transaction.
- **Reset mid-operation:** on the next edge, return to IDLE and apply all reset values. The in-flight access is abandoned with no ack, and `mem_we` drops immediately.
- **Simultaneous reset and request:** reset wins; the request is seen in the first IDLE cycle after `rst` deasserts.
- **RD_LAT=1:** a read takes a single ACCESS cycle, identical in timing to a write.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with both reqs high → all outputs 0 and `owner`=1. After release, CPU is granted first.
- **CPU read:** `mem[0x05]`=0x1234, `cpu_req`=1, `cpu_we`=0, `cpu_addr`=0x005 → `mem_en` high for 3 cycles at address 0x005. `cpu_ack` pulses in cycle 4 with `rdata`=0x1234; `dma_ack` stays 0.
- **DMA write:** `dma_addr`=0x3FF, `dma_wdata`=0xBEEF → `mem_we` high exactly 1 cycle and `dma_ack` at cycle 2. A subsequent CPU read of 0x3FF returns 0xBEEF.
- **Contention:** both requesters issue reads in the same cycle, 3 back-to-back rounds → grant order CPU, DMA, CPU. Acks at cycles 4, 9, 14. `owner` toggles each round and the two acks are never simultaneous.
- **Reset mid-read:** assert `rst` in the 2nd ACCESS cycle → next cycle IDLE, `mem_en`=0, no ack. The re-issued read completes normally with the correct data.
- **Late request:** `dma_req` rises during a CPU ACCESS with a different address → the CPU's `mem_addr` is unchanged. DMA is granted in the IDLE after the CPU's DONE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes and memory-side bus of mem_arbiter
interface mem_arbiter_if #(parameter int ADDR_W = 10, parameter int DATA_W = 16);
  logic cpu_req, cpu_we, cpu_ack, dma_req, dma_we, dma_ack, mem_en, mem_we, busy, owner;
  logic [ADDR_W-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata, rdata, mem_wdata, mem_rdata;
  modport slave (
    input cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    output cpu_ack, dma_ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    input cpu_ack, dma_ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin CPU/DMA arbiter for a single-port memory with fixed read latency
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 3
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(RD_LAT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic any_req, pick, pick_we;
  // pick: 1 = DMA; on a tie the requester that did not win last time goes
  always_comb begin
    any_req = bus.cpu_req | bus.dma_req;
    pick = (bus.cpu_req & bus.dma_req) ? ~bus.owner : bus.dma_req;
    pick_we = pick ? bus.dma_we : bus.cpu_we;
    state_nx = state == IDLE ? (any_req ? ACCESS : IDLE) :
               state == ACCESS ? (cnt == '0 ? DONE : ACCESS) : IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      bus.owner <= 1'b1;
      bus.cpu_ack <= 1'b0;
      bus.dma_ack <= 1'b0;
      bus.rdata <= '0;
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.dma_ack <= 1'b0;
      if (state == IDLE && any_req) begin
        bus.owner <= pick;
        bus.mem_en <= 1'b1;
        bus.mem_we <= pick_we;
        bus.mem_addr <= pick ? bus.dma_addr : bus.cpu_addr;
        bus.mem_wdata <= pick ? bus.dma_wdata : bus.cpu_wdata;
        cnt <= pick_we ? '0 : CW'(RD_LAT - 1);
      end else if (state == ACCESS) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          if (!bus.mem_we) bus.rdata <= bus.mem_rdata;
          bus.cpu_ack <= ~bus.owner;
          bus.dma_ack <= bus.owner;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table, corner sequences and randomized rounds against a transaction model
module tb_mem_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 3;
  typedef struct {
    logic cr, cw;
    logic [9:0] ca;
    logic [15:0] cd;
    logic dr, dw;
    logic [9:0] da;
    logic [15:0] dd;
    int ds, ck, dk;
    logic [15:0] crd, drd;
    logic own;
  } vec_t;
  logic clk, rst;
  int tests, fails;
  logic [15:0] mem [1024];
  logic [15:0] m_mem [1024];
  logic [15:0] m_rdata;
  logic m_own;
  int en_age;
  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  initial clk = 0;
  always #5 clk = ~clk;
  // memory device: read data only becomes valid RD_LAT cycles into the enable
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'hA000 | 16'(i);
    mem[5] = 16'h1234;
    en_age = 0;
    forever begin
      @(posedge clk);
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      en_age <= bus.mem_en ? en_age + 1 : 0;
    end
  end
  assign bus.mem_rdata = (bus.mem_en && en_age >= RD_LAT - 1) ? mem[bus.mem_addr] : 16'hDEAD;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic int lat(input logic we);
    return we ? 2 : RD_LAT + 1;
  endfunction
  task automatic chk_reset_state(input string n);
    chk({n, "_acks"}, {bus.cpu_ack, bus.dma_ack}, 0);
    chk({n, "_rdata"}, bus.rdata, 0);
    chk({n, "_busy"}, bus.busy, 0);
    chk({n, "_mem_en_we"}, {bus.mem_en, bus.mem_we}, 0);
    chk({n, "_mem_addr"}, bus.mem_addr, 0);
    chk({n, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({n, "_owner"}, bus.owner, 1);
  endtask
  task automatic do_reset();
    bus.cpu_req = 0;
    bus.dma_req = 0;
    rst = 1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 0;
  endtask
  task automatic model_serve(input logic who, input logic we, input logic [9:0] a, input logic [15:0] d,
                             output logic [15:0] rd);
    if (we) m_mem[a] = d;
    else m_rdata = m_mem[a];
    rd = m_rdata;
    m_own = who;
  endtask
  // Called with the DUT in IDLE; returns with the DUT back in IDLE.
  task automatic run_round(input vec_t v);
    int k, en_n, we_n, fl;
    logic cdone, ddone, cfirst;
    logic [9:0] fa;
    bus.cpu_we = v.cw; bus.cpu_addr = v.ca; bus.cpu_wdata = v.cd;
    bus.dma_we = v.dw; bus.dma_addr = v.da; bus.dma_wdata = v.dd;
    bus.cpu_req = v.cr;
    bus.dma_req = v.dr && v.ds == 0;
    cdone = !v.cr; ddone = !v.dr;
    cfirst = v.cr && (!v.dr || v.ck < v.dk);
    fa = cfirst ? v.ca : v.da;
    fl = cfirst ? (v.cw ? 1 : RD_LAT) : (v.dw ? 1 : RD_LAT);
    en_n = 0; we_n = 0; k = 0;
    while (!(cdone && ddone) && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (v.dr && k == v.ds) bus.dma_req = 1;
      en_n += int'(bus.mem_en);
      we_n += int'(bus.mem_we);
      if (bus.mem_we && !bus.mem_en) chk("mem_we_outside_access", 1, 0);
      if (k <= fl) chk("mem_addr_hold", bus.mem_addr, fa);
      if (bus.cpu_ack && bus.dma_ack) chk("both_acks", 1, 0);
      if (bus.cpu_ack) begin
        chk("cpu_ack_expected", v.cr && !cdone, 1);
        chk("cpu_ack_cycle", k, v.ck);
        chk("cpu_rdata", bus.rdata, v.crd);
        cdone = 1;
        bus.cpu_req = 0;
      end
      if (bus.dma_ack) begin
        chk("dma_ack_expected", v.dr && !ddone, 1);
        chk("dma_ack_cycle", k, v.dk);
        chk("dma_rdata", bus.rdata, v.drd);
        ddone = 1;
        bus.dma_req = 0;
      end
    end
    chk("round_done", cdone && ddone, 1);
    bus.cpu_req = 0;
    bus.dma_req = 0;
    chk("owner", bus.owner, v.own);
    chk("mem_en_cycles", en_n, (v.cr ? (v.cw ? 1 : RD_LAT) : 0) + (v.dr ? (v.dw ? 1 : RD_LAT) : 0));
    chk("mem_we_cycles", we_n, int'(v.cr && v.cw) + int'(v.dr && v.dw));
    @(posedge clk); #1;
  endtask
  initial begin
    vec_t tbl [9];
    vec_t v;
    int n, sel;
    logic re_c, re_d, first;
    tests = 0; fails = 0;
    for (int i = 0; i < 1024; i++) m_mem[i] = 16'hA000 | 16'(i);
    tbl[0] = '{1, 0, 10'h005, 16'h0, 1, 0, 10'h001, 16'h0, 0, 4, 9, 16'h1234, 16'hA001, 1};
    tbl[1] = '{0, 0, 10'h000, 16'h0, 1, 1, 10'h3FF, 16'hBEEF, 0, 0, 2, 16'h0, 16'hA001, 1};
    tbl[2] = '{1, 0, 10'h3FF, 16'h0, 0, 0, 10'h000, 16'h0, 0, 4, 0, 16'hBEEF, 16'h0, 0};
    tbl[3] = '{1, 1, 10'h010, 16'h5555, 1, 0, 10'h010, 16'h0, 0, 7, 4, 16'hA010, 16'hA010, 0};
    tbl[4] = '{1, 0, 10'h010, 16'h0, 1, 1, 10'h020, 16'h7777, 0, 7, 2, 16'h5555, 16'hA010, 0};
    tbl[5] = '{1, 1, 10'h030, 16'h1111, 1, 1, 10'h030, 16'h2222, 0, 5, 2, 16'h5555, 16'h5555, 0};
    tbl[6] = '{0, 0, 10'h000, 16'h0, 1, 0, 10'h030, 16'h0, 0, 0, 4, 16'h0, 16'h1111, 1};
    tbl[7] = '{1, 0, 10'h020, 16'h0, 0, 0, 10'h000, 16'h0, 0, 4, 0, 16'h7777, 16'h0, 0};
    tbl[8] = '{1, 0, 10'h005, 16'h0, 1, 0, 10'h001, 16'h0, 2, 4, 9, 16'h1234, 16'hA001, 1};
    // reset held with both requests high, then a continuous two-requester read stream
    bus.cpu_we = 0; bus.cpu_addr = 10'h005; bus.cpu_wdata = 0;
    bus.dma_we = 0; bus.dma_addr = 10'h001; bus.dma_wdata = 0;
    bus.cpu_req = 1; bus.dma_req = 1;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk_reset_state("reset");
    end
    rst = 0;
    n = 0; re_c = 0; re_d = 0;
    for (int k = 1; k <= 30 && n < 3; k++) begin
      @(posedge clk); #1;
      if (re_c) begin bus.cpu_req = 1; re_c = 0; end
      if (re_d) begin bus.dma_req = 1; re_d = 0; end
      if (bus.cpu_ack && bus.dma_ack) chk("cont_both_acks", 1, 0);
      if (bus.cpu_ack || bus.dma_ack) begin
        chk("cont_who", bus.dma_ack, n == 1);
        chk("cont_cycle", k, 4 + 5 * n);
        chk("cont_owner", bus.owner, n == 1);
        chk("cont_rdata", bus.rdata, n == 1 ? 16'hA001 : 16'h1234);
        if (bus.cpu_ack) begin bus.cpu_req = 0; re_c = 1; end
        else begin bus.dma_req = 0; re_d = 1; end
        n++;
      end
    end
    chk("cont_rounds", n, 3);
    do_reset();
    for (int i = 0; i < 9; i++) run_round(tbl[i]);
    // reset in the second ACCESS cycle of a read abandons it without an ack
    bus.cpu_we = 0; bus.cpu_addr = 10'h3FF; bus.cpu_req = 1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1; bus.cpu_req = 0;
    @(posedge clk); #1;
    chk_reset_state("midrst");
    rst = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst_quiet", {bus.cpu_ack, bus.dma_ack, bus.busy}, 0);
    end
    v = '{1, 0, 10'h3FF, 16'h0, 0, 0, 10'h000, 16'h0, 0, 4, 0, 16'hBEEF, 16'h0, 0};
    run_round(v);
    do_reset();
    m_own = 1; m_rdata = 0;
    for (int r = 0; r < 40; r++) begin
      sel = $urandom_range(1, 3);
      v = '{default: 0};
      v.cr = sel[0]; v.dr = sel[1];
      v.cw = 1'($urandom_range(0, 1)); v.dw = 1'($urandom_range(0, 1));
      v.ca = 10'h100 + 10'($urandom_range(0, 7)); v.da = 10'h100 + 10'($urandom_range(0, 7));
      v.cd = 16'($urandom); v.dd = 16'($urandom);
      first = (v.cr && v.dr) ? ~m_own : v.dr;
      if (first) begin model_serve(1, v.dw, v.da, v.dd, v.drd); v.dk = lat(v.dw); end
      else begin model_serve(0, v.cw, v.ca, v.cd, v.crd); v.ck = lat(v.cw); end
      if (v.cr && v.dr) begin
        if (first) begin model_serve(0, v.cw, v.ca, v.cd, v.crd); v.ck = v.dk + 1 + lat(v.cw); end
        else begin model_serve(1, v.dw, v.da, v.dd, v.drd); v.dk = v.ck + 1 + lat(v.dw); end
      end
      v.own = m_own;
      run_round(v);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
